pipo_load_arbiter: RTL and testbench

Round-robin arbiter and load sequencer for a shared 4-bit parallel-in parallel-out holding register. Up to NREQ requesters each present a data word and a request. The block selects one fairly and loads its word into the register. It then returns a one-cycle acknowledge to the winner. It sits between requesting datapath units and the shared register; the register itself is implemented inside this block.

---
 rtl/pipo_load_arbiter_if.sv | 27 ++
 rtl/pipo_load_arbiter.sv | 87 ++++++++
 tb/tb_pipo_load_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipo_load_arbiter_if.sv
// Requester-side bundle for the shared holding-register arbiter: requests and
// data in; grant, acknowledge and register view out.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [IDXW-1:0]       owner;
  logic                  busy;

  modport master (
    output req, din,
    input  gnt, ack, q, q_valid, owner, busy
  );

  modport slave (
    input  req, din,
    output gnt, ack, q, q_valid, owner, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared holding
// register per IDLE -> LOAD -> DONE transaction and pulses ack to the winner.
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input logic              clk,
  input logic              rst,
  pipo_load_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] pick;
  logic [NREQ-1:0] win_oh;

  // First set request bit at or after p, wrapping; scanning downward lets the
  // nearest candidate overwrite the farther ones.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] p);
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] ix;
    int              idx;
    sel = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      ix  = IDXW'(idx);
      if (r[ix]) sel = ix;
    end
    return sel;
  endfunction

  function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] w);
    return (w == IDXW'(NREQ - 1)) ? '0 : w + 1'b1;
  endfunction

  assign pick   = rr_pick(bus.req, ptr);
  assign win_oh = NREQ'(1) << win;

  // Handshake outputs depend only on registered state and the latched winner.
  assign bus.gnt  = (state == LOAD) ? win_oh : '0;
  assign bus.ack  = (state == DONE) ? win_oh : '0;
  assign bus.busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = LOAD;
      LOAD:    state_nxt = bus.req[win] ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.owner   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|bus.req) win <= pick;
        LOAD: begin
          if (bus.req[win]) begin
            bus.q       <= bus.din[win*WIDTH +: WIDTH];
            bus.owner   <= win;
            bus.q_valid <= 1'b1;
          end
        end
        DONE:    ptr <= next_ptr(win);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, acks and the
// register view; a negedge monitor checks the DUT against those predictions.
module tb_pipo_load_arbiter;
  localparam int W = 4;
  localparam int N = 4;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           edge_no;
  } rec_t;

  logic clk;
  logic rst;
  pipo_load_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  pipo_load_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  rec_t gq[$];
  rec_t aq[$];

  // Model state: transaction timeline rather than explicit FSM states.
  int           edge_cnt = 0;
  int           won_at   = -1;
  int           winner   = 0;
  int           rr_ptr   = 0;
  logic [W-1:0] q_m      = '0;
  logic         qv_m     = 1'b0;
  int           own_m    = 0;
  logic         busy_m   = 1'b0;

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        won_at = -1; rr_ptr = 0; q_m = '0; qv_m = 1'b0; own_m = 0; busy_m = 1'b0;
      end else if (won_at < 0) begin
        if (bus.req != '0) begin
          winner = model_pick(bus.req, rr_ptr);
          won_at = edge_cnt;
          gq.push_back('{winner, '0, edge_cnt});
          busy_m = 1'b1;
        end
      end else if (edge_cnt == won_at + 1) begin
        if (bus.req[winner]) begin
          q_m   = bus.din[winner*W +: W];
          qv_m  = 1'b1;
          own_m = winner;
          aq.push_back('{winner, q_m, edge_cnt});
        end else begin
          won_at = -1;
          busy_m = 1'b0;
        end
      end else begin
        rr_ptr = (winner + 1) % N;
        won_at = -1;
        busy_m = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  initial begin
    rec_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (gq.size() > 0 && gq[0].edge_no == edge_cnt) begin
        r = gq.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(1) << r.idx);
      end else begin
        chk("gnt_quiet", 32'(bus.gnt), 32'd0);
      end
      if (aq.size() > 0 && aq[0].edge_no == edge_cnt) begin
        r = aq.pop_front();
        chk("ack", 32'(bus.ack), 32'(1) << r.idx);
        chk("ack_q", 32'(bus.q), 32'(r.data));
        chk("ack_owner", 32'(bus.owner), 32'(r.idx));
      end else begin
        chk("ack_quiet", 32'(bus.ack), 32'd0);
      end
      chk("q", 32'(bus.q), 32'(q_m));
      chk("q_valid", 32'(bus.q_valid), 32'(qv_m));
      chk("owner", 32'(bus.owner), 32'(own_m));
      chk("busy", 32'(bus.busy), 32'(busy_m));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    rst     = 1'b1;
    bus.req = N'($urandom);
    bus.din = (N*W)'($urandom);
    cycles(2);
    rst = 1'b0; bus.req = '0;
    cycles(3);

    // single requester 2 with data 1010
    bus.din = 16'h0A00; bus.req = 4'b0100;
    cycles(3);
    bus.req = '0;
    cycles(2);

    // round-robin from a fresh pointer, including the 3 -> 0 wrap
    rst = 1'b1; cycles(1); rst = 1'b0;
    bus.din = 16'h4321; bus.req = 4'b1111;
    cycles(15);
    bus.req = '0;
    cycles(2);

    // move ptr to 2, then late arrivals 0 and 1, then requester 3 alone
    bus.req = 4'b0010; cycles(3);
    bus.req = 4'b0011; cycles(6);
    bus.req = '0;      cycles(1);
    bus.req = 4'b1000; cycles(3);
    bus.req = '0;      cycles(2);

    // abort: requester 0 drops during LOAD
    bus.din = 16'h5678;
    bus.req = 4'b0001; cycles(1);
    bus.req = '0;      cycles(3);
    bus.req = 4'b0011; cycles(3);
    bus.req = '0;      cycles(2);

    // reset during LOAD of an all-ones word
    bus.din = 16'h000F;
    bus.req = 4'b0001; cycles(1);
    rst = 1'b1;        cycles(1);
    rst = 1'b0; bus.req = '0; cycles(2);
    bus.din = 16'h9C3B;
    bus.req = 4'b1010; cycles(3);
    bus.req = '0;      cycles(2);

    // randomized traffic, including aborts, held requests and rare resets
    r = '0;
    d = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
        if ($urandom_range(0, 2) == 0) d[i*W +: W] = W'($urandom);
      end
      rst     = ($urandom_range(0, 149) == 0);
      bus.req = r;
      bus.din = d;
      cycles(1);
    end
    rst = 1'b0; bus.req = '0;
    cycles(4);

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
